// File: rtl/boron_pkg.sv
// Shared constants, state encoding and helpers for the Boron block loader.
// Imported by boron_word_packer and boron_block_loader.
package boron_pkg;

    localparam int BLOCK_W     = 64;
    localparam int KEY_W       = 80;
    localparam int WORD_W      = 16;
    localparam int KEY_WORDS   = 5;
    localparam int PT_WORDS    = 4;
    localparam int FRAME_W     = KEY_W + BLOCK_W;
    localparam int FRAME_WORDS = KEY_WORDS + PT_WORDS;

    localparam logic [3:0] LAST_IDX     = 4'(FRAME_WORDS - 1);
    localparam logic [3:0] FIRST_PT_IDX = 4'(KEY_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    function automatic logic is_last(input logic [3:0] idx);
        return idx == LAST_IDX;
    endfunction

endpackage

// File: rtl/boron_word_packer.sv
// Shift-in packer: 16-bit words enter at the bottom of a 144-bit register,
// so after 9 loads word 0 sits in key[79:64] and word 8 in plain[15:0].
// Ports: clk, rst (sync, active-high), load (shift enable), pt_only
// (shift only the 64-bit plaintext half, key half untouched), word (16),
// key (80), plain (64).
module boron_word_packer
    import boron_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               pt_only,
    input  logic [WORD_W-1:0]  word,
    output logic [KEY_W-1:0]   key,
    output logic [BLOCK_W-1:0] plain
);

    logic [FRAME_W-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            if (pt_only) begin
                sr[BLOCK_W-1:0] <= {sr[BLOCK_W-WORD_W-1:0], word};
            end else begin
                sr <= {sr[FRAME_W-WORD_W-1:0], word};
            end
        end
    end

    assign key   = sr[FRAME_W-1:BLOCK_W];
    assign plain = sr[BLOCK_W-1:0];

endmodule

// File: rtl/boron_block_loader.sv
// Boron block loader: collects a key+plaintext frame of 16-bit words,
// starts the encryption core, waits (with timeout) and hands out the result.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_new_key
// input stream; core_start/core_plain/core_key/core_done/core_cipher core
// side; out_valid/out_ready/out_data result; busy, err (sticky timeout).
// Parameter TIMEOUT_CYC: WAIT cycles allowed before err.
// Macro BORON_KEY_REUSE_EN: in_new_key=0 on the first word selects a
// 4-word plaintext-only frame that keeps the previous key.
module boron_block_loader
    import boron_pkg::*;
#(
    parameter int TIMEOUT_CYC = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_new_key,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_plain,
    output logic [KEY_W-1:0]   core_key,
    input  logic               core_done,
    input  logic [BLOCK_W-1:0] core_cipher,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy,
    output logic               err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYC - 1);

    state_t             state;
    state_t             state_nx;
    logic [3:0]         idx;
    logic [3:0]         idx_base;
    logic [CW-1:0]      wait_cnt;
    logic [BLOCK_W-1:0] out_q;
    logic               err_q;
    logic               accept;
    logic               pt_only;
    logic               in_wait;
    logic               timeout;

    // in_ready is forced low while rst is asserted, not only after it.
    assign in_ready = !rst && (state == ST_IDLE || state == ST_LOAD);
    assign accept   = in_valid && in_ready;
    assign in_wait  = (state == ST_WAIT);
    assign timeout  = in_wait && !core_done && (wait_cnt == WAIT_LAST);

`ifdef BORON_KEY_REUSE_EN
    logic short_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            short_q <= 1'b0;
        end else if (accept && state == ST_IDLE) begin
            short_q <= !in_new_key;
        end
    end

    // The first word decides the frame type before short_q is loaded.
    assign pt_only = (state == ST_IDLE) ? !in_new_key : short_q;
`else
    logic unused_new_key;

    assign unused_new_key = in_new_key;
    assign pt_only        = 1'b0;
`endif

    // A short frame starts at the first plaintext index so both frame
    // types end on the same last index.
    assign idx_base = (state == ST_IDLE && pt_only) ? FIRST_PT_IDX : idx;

    always_comb begin
        state_nx   = state;
        core_start = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && is_last(idx)) begin
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                core_start = 1'b1;
                state_nx   = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    state_nx = ST_OUT;
                end else if (timeout) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            wait_cnt <= '0;
            out_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                idx <= is_last(idx_base) ? 4'd0 : idx_base + 4'd1;
            end
            wait_cnt <= in_wait ? wait_cnt + 1'b1 : '0;
            if (in_wait && core_done) begin
                out_q <= core_cipher;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    boron_word_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .pt_only (pt_only),
        .word    (in_data),
        .key     (core_key),
        .plain   (core_plain)
    );

    assign out_data = out_q;
    assign busy     = (state != ST_IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_boron_block_loader.sv
// Randomized self-checking bench for boron_block_loader with a frame-level
// reference model (word lists -> expected key/plain, delay -> timeout/err).
module tb_boron_block_loader;

    localparam int TO = 32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_new_key;
    logic        core_start;
    logic [63:0] core_plain;
    logic [79:0] core_key;
    logic        core_done;
    logic [63:0] core_cipher;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
    logic        err;

    boron_block_loader #(.TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_new_key  (in_new_key),
        .core_start  (core_start),
        .core_plain  (core_plain),
        .core_key    (core_key),
        .core_done   (core_done),
        .core_cipher (core_cipher),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    logic [15:0] fw [9];
    int          fn;
    bit          fnk;
    logic [79:0] m_key;
    logic [63:0] m_plain;
    logic [63:0] m_out;
    bit          m_err;

    task automatic check(input string tag, input logic [143:0] obs,
                         input logic [143:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic calc_model();
        if (fn == 9) m_key = {fw[0], fw[1], fw[2], fw[3], fw[4]};
        m_plain = {fw[fn-4], fw[fn-3], fw[fn-2], fw[fn-1]};
    endtask

    task automatic make_frame(input bit nk);
        fnk = nk;
`ifdef BORON_KEY_REUSE_EN
        fn = nk ? 9 : 4;
`else
        fn = 9;
`endif
        for (int i = 0; i < fn; i++) fw[i] = 16'($urandom);
        calc_model();
    endtask

    task automatic push_words(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            bit ok;
            int guard;
            ok = 0;
            guard = 0;
            while (!ok) begin
                in_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data    = in_valid ? fw[i] : 16'($urandom);
                in_new_key = (i == 0) ? fnk : 1'($urandom_range(0, 1));
                ok = in_valid && in_ready;
                tick();
                guard++;
                if (!ok && guard > 100) begin
                    check("accept_bound", {143'b0, in_ready}, 144'd1);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        push_words(fn, gaps);
        check("start_pulse", core_start, 1);
        check("core_key", core_key, m_key);
        check("core_plain", core_plain, m_plain);
        check("start_in_ready", in_ready, 0);
    endtask

    task automatic run_core(input int d, input logic [63:0] cipher,
                            input int hold);
        int bad;
        bit got;
        bad = 0;
        got = 0;
        tick();
        check("start_len", core_start, 0);
        for (int j = 1; j <= TO; j++) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
            if (core_key !== m_key || core_plain !== m_plain) bad++;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
            core_cipher = (j == d) ? cipher : 64'({$urandom, $urandom});
            core_done   = (j == d);
            tick();
            core_done = 1'b0;
            if (j == d) begin
                got = 1;
                break;
            end
        end
        in_valid = 1'b0;
        check("wait_phase", bad, 0);
        if (got) begin
            m_out = cipher;
            core_cipher = 64'({$urandom, $urandom});
            check("out_valid", out_valid, 1);
            check("out_data", out_data, m_out);
            bad = 0;
            for (int h = 0; h < hold; h++) begin
                out_ready = 1'b0;
                tick();
                if (out_valid !== 1'b1 || out_data !== m_out) bad++;
                if (in_ready !== 1'b0) bad++;
            end
            check("out_hold", bad, 0);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("out_accept_valid", out_valid, 0);
            check("out_accept_busy", busy, 0);
            check("out_accept_ready", in_ready, 1);
        end else begin
            m_err = 1;
            check("timeout_busy", busy, 0);
            check("timeout_out_valid", out_valid, 0);
        end
        check("err", err, m_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_new_key = 1'b0;
        core_done = 1'b0;
        core_cipher = '0;
        out_ready = 1'b0;
        m_key = '0;
        m_plain = '0;
        m_out = '0;
        m_err = 0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_core_start", core_start, 0);
        check("rst_key", core_key, 0);
        check("rst_plain", core_plain, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        fn = 9;
        fnk = 1;
        fw = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0011,
               16'h0000, 16'h1111, 16'h2222, 16'h3333};
        calc_model();
        check("vec_key_model", m_key, 80'h0123456789ABCDEF0011);
        send_frame(0);
        run_core(26, 64'hDEADBEEFCAFEF00D, 5);

        core_cipher = 64'h1234_5678_9ABC_DEF0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("idle_done_valid", out_valid, 0);
        check("idle_done_busy", busy, 0);
        check("idle_done_data", out_data, m_out);

        make_frame(1);
        send_frame(1);
        run_core(TO, 64'({$urandom, $urandom}), 0);

        make_frame(1);
        send_frame(0);
        run_core(1, 64'({$urandom, $urandom}), 2);

        make_frame(1);
        send_frame(0);
        run_core(TO + 1, 64'h0, 0);

        fn = 9;
        fnk = 1;
        fw = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0011,
               16'h0000, 16'h1111, 16'h2222, 16'h3333};
        calc_model();
        send_frame(1);
        run_core(5, 64'h0F0E_0D0C_0B0A_0908, 1);

        make_frame(1);
        push_words(4, 0);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_key", core_key, 0);
        check("midrst_plain", core_plain, 0);
        check("midrst_err", err, 0);
        rst = 1'b0;
        m_key = '0;
        m_plain = '0;
        m_out = '0;
        m_err = 0;
        #1;
        check("midrst_after_ready", in_ready, 1);
        core_done = 1'b1;
        core_cipher = 64'hFFFF_0000_FFFF_0000;
        tick();
        core_done = 1'b0;
        check("midrst_late_done", out_valid, 0);
        make_frame(1);
        send_frame(0);
        run_core(3, 64'({$urandom, $urandom}), 0);

`ifdef BORON_KEY_REUSE_EN
        make_frame(1);
        send_frame(0);
        run_core(4, 64'({$urandom, $urandom}), 0);
        fn = 4;
        fnk = 0;
        fw[0] = 16'hAAAA;
        fw[1] = 16'hBBBB;
        fw[2] = 16'hCCCC;
        fw[3] = 16'hDDDD;
        calc_model();
        check("reuse_plain_model", m_plain, 64'hAAAABBBBCCCCDDDD);
        send_frame(0);
        run_core(6, 64'({$urandom, $urandom}), 0);
`endif

        for (int k = 0; k < 25; k++) begin
            make_frame(1'($urandom_range(0, 1)));
            send_frame(1'($urandom_range(0, 1)));
            run_core(int'($urandom_range(1, TO + 3)),
                     64'({$urandom, $urandom}),
                     int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/boron_block_loader.md
BORON_BLOCK_LOADER -- requirements
Module: boron_block_loader

Interface
REQ-001 Parameter TIMEOUT_CYC, default 32: maximum WAIT cycles allowed for core_done before error.
REQ-002 clk  input  1  rising-edge clock; only clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  input word valid.
REQ-005 in_ready  output  1  block accepts input word; a word transfers when in_valid && in_ready.
REQ-006 in_data  input  16  input word; key words first, then plaintext words, most-significant word first.
REQ-007 in_new_key  input  1  sampled on the first word of a frame; used only when BORON_KEY_REUSE_EN is defined.
REQ-008 core_start  output  1  one-cycle start pulse to the Boron encryption core.
REQ-009 core_plain  output  64  assembled plaintext block.
REQ-010 core_key  output  80  assembled 80-bit master key.
REQ-011 core_done  input  1  core finished; core_cipher is valid while this is high.
REQ-012 core_cipher  input  64  ciphertext from the core.
REQ-013 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-014 out_data  output  64  captured ciphertext.
REQ-015 busy  output  1  high when state != IDLE.
REQ-016 err  output  1  sticky timeout flag.

Function
REQ-017 States SHALL be IDLE, LOAD, START, WAIT, OUT.
REQ-018 in_ready SHALL be 1 only in IDLE and LOAD; it is 0 in START, WAIT and OUT, so frames never overlap.
REQ-019 A frame SHALL be 9 words: key words 0-4 fill core_key[79:64] down to core_key[15:0], then plaintext words 5-8 fill core_plain[63:48] down to core_plain[15:0].
REQ-020 The first accepted word SHALL move IDLE->LOAD; a 4-bit word counter counts 0..8, and in_valid low stalls with no state change.
REQ-021 Acceptance of the last word SHALL move to START on the next edge; core_start is high for exactly that one cycle (latency 1).
REQ-022 core_plain and core_key SHALL stay stable from START until leaving WAIT.
REQ-023 In WAIT, core_done=1 SHALL latch core_cipher into out_data and move to OUT, with out_valid=1 on the next cycle.
REQ-024 A WAIT cycle counter SHALL, on reaching TIMEOUT_CYC without core_done, set err=1 and move to IDLE; if core_done arrives in the same cycle, core_done wins and err is not set.
REQ-025 core_done outside WAIT SHALL be ignored.
REQ-026 out_data and out_valid SHALL hold while out_valid && !out_ready; acceptance clears out_valid and moves to IDLE on the same edge.
REQ-027 err SHALL be cleared only by rst; it does not block new frames.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL enter IDLE; in_ready=0 during reset and 1 afterwards; core_start, out_valid, busy, err, out_data, core_plain, core_key and all counters reset to 0.
REQ-029 Reset mid-frame or mid-WAIT SHALL discard partial data; a later core_done SHALL be ignored.

Configuration
REQ-030 With BORON_KEY_REUSE_EN defined, in_new_key=0 on the first word SHALL make the frame 4 plaintext words only, and core_key SHALL keep the previous key (0 after reset).
REQ-031 With BORON_KEY_REUSE_EN defined, in_new_key=1 SHALL select a 9-word frame as in REQ-019.
REQ-032 Without BORON_KEY_REUSE_EN, every frame SHALL be 9 words, in_new_key is ignored, and no logic is generated for it.

Structure
REQ-033 Package boron_pkg SHALL hold BLOCK_W=64, KEY_W=80, WORD_W=16, KEY_WORDS=5, PT_WORDS=4 and the state encoding.
REQ-034 Sub-module boron_word_packer (16-bit shift-in packing into 144 bits, with load enable) SHALL be the only sub-module.

Verification
REQ-035 Words 0x0123,0x4567,0x89AB,0xCDEF,0x0011 then 0x0000,0x1111,0x2222,0x3333 -> core_key=0x0123456789ABCDEF0011, core_plain=0x0000111122223333, core_start pulses 1 cycle after the 9th word.
REQ-036 Core stub asserts core_done 26 cycles after start with cipher 0xDEADBEEFCAFEF00D; out_ready held 0 for 5 cycles -> out_data is stable and out_valid is held, then returns to IDLE on accept.
REQ-037 No core_done, TIMEOUT_CYC=32 -> err=1 after 32 WAIT cycles, state IDLE; the next frame completes normally with err still 1.
REQ-038 rst pulsed after word 4 -> in_ready=0 during reset and 1 after; busy=0; the following 9-word frame yields correct key and plaintext with no residue.
REQ-039 With BORON_KEY_REUSE_EN: a 9-word frame, then in_new_key=0 with 4 words 0xAAAA,0xBBBB,0xCCCC,0xDDDD -> core_key unchanged, core_plain=0xAAAABBBBCCCCDDDD.
REQ-040 in_valid toggled randomly during LOAD -> identical result to back-to-back input; in_ready=0 throughout WAIT and OUT.
